// File: rtl/rs_scheduler_pkg.sv
// Shared widths, opcode encodings and the issue payload type for the ALU reservation station.
// RS_OLDEST_FIRST_EN selects the age-matrix picker; when undefined, lowest index wins.
package rs_scheduler_pkg;

   localparam int DATA_LEN           = 32;
   localparam int ADDR_LEN           = 32;
   localparam int OPENUM_LEN         = 6;
   localparam int RS_SIZE_DEFAULT    = 16;
   localparam int ROB_ID_LEN_DEFAULT = 4;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam logic [DATA_LEN-1:0] ZERO_WORD = '0;
   localparam logic [ADDR_LEN-1:0] ZERO_ADDR = '0;

   localparam logic [OPENUM_LEN-1:0] OPENUM_NOP  = 6'd0;
   localparam logic [OPENUM_LEN-1:0] OPENUM_ADD  = 6'd1;
   localparam logic [OPENUM_LEN-1:0] OPENUM_SUB  = 6'd2;
   localparam logic [OPENUM_LEN-1:0] OPENUM_ADDI = 6'd3;
   localparam logic [OPENUM_LEN-1:0] OPENUM_AND  = 6'd4;
   localparam logic [OPENUM_LEN-1:0] OPENUM_OR   = 6'd5;
   localparam logic [OPENUM_LEN-1:0] OPENUM_XOR  = 6'd6;
   localparam logic [OPENUM_LEN-1:0] OPENUM_SLT  = 6'd7;
   localparam logic [OPENUM_LEN-1:0] OPENUM_BEQ  = 6'd8;
   localparam logic [OPENUM_LEN-1:0] OPENUM_BNE  = 6'd9;
   localparam logic [OPENUM_LEN-1:0] OPENUM_JAL  = 6'd10;
   localparam logic [OPENUM_LEN-1:0] OPENUM_JALR = 6'd11;

   typedef struct packed {
      logic [OPENUM_LEN-1:0] openum;
      logic [DATA_LEN-1:0]   v1;
      logic [DATA_LEN-1:0]   v2;
      logic [DATA_LEN-1:0]   imm;
      logic [ADDR_LEN-1:0]   pc;
   } rs_op_t;

   localparam rs_op_t NOP_OP = '{openum: OPENUM_NOP, v1: ZERO_WORD, v2: ZERO_WORD,
                                 imm: ZERO_WORD, pc: ZERO_ADDR};

endpackage

// File: rtl/rs_select.sv
// Combinational picker: ready vector -> one-hot grant and index.
// RS_OLDEST_FIRST_EN picks the ready entry with no older ready entry; otherwise lowest index.
module rs_select #(
   parameter int N     = 16,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]        ready,
`ifdef RS_OLDEST_FIRST_EN
   input  logic [N-1:0][N-1:0] older,
`endif
   output logic [N-1:0]        grant,
   output logic [IDX_W-1:0]    idx,
   output logic                any
);

   always_comb begin
      grant = '0;
      idx   = '0;
`ifdef RS_OLDEST_FIRST_EN
      // older[i][j] set means j entered before i; busy entries form a total order
      for (int i = 0; i < N; i++) begin
         if (ready[i] && !(|(older[i] & ready))) begin
            grant[i] = 1'b1;
            idx      = IDX_W'(i);
         end
      end
`else
      for (int i = N - 1; i >= 0; i--) begin
         if (ready[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            idx      = IDX_W'(i);
         end
      end
`endif
   end

   assign any = |ready;

endmodule

// File: rtl/rs_scheduler.sv
// ALU reservation station: buffers ops, wakes operands from CDB and own broadcast, issues one per cycle.
// RS_OLDEST_FIRST_EN enables the age-matrix select in rs_select.
module rs_scheduler
   import rs_scheduler_pkg::*;
#(
   parameter int RS_SIZE    = RS_SIZE_DEFAULT,
   parameter int ROB_ID_LEN = ROB_ID_LEN_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  rollback,
   input  logic                  in_valid,
   input  logic [OPENUM_LEN-1:0] in_openum,
   input  logic [DATA_LEN-1:0]   in_V1,
   input  logic [DATA_LEN-1:0]   in_V2,
   input  logic                  in_Q1_busy,
   input  logic                  in_Q2_busy,
   input  logic [ROB_ID_LEN-1:0] in_Q1,
   input  logic [ROB_ID_LEN-1:0] in_Q2,
   input  logic [DATA_LEN-1:0]   in_imm,
   input  logic [ADDR_LEN-1:0]   in_pc,
   input  logic [ROB_ID_LEN-1:0] in_rob_id,
   output logic                  full,
   input  logic                  cdb_valid,
   input  logic [ROB_ID_LEN-1:0] cdb_rob_id,
   input  logic [DATA_LEN-1:0]   cdb_value,
   output logic [OPENUM_LEN-1:0] ex_openum,
   output logic [DATA_LEN-1:0]   ex_V1,
   output logic [DATA_LEN-1:0]   ex_V2,
   output logic [DATA_LEN-1:0]   ex_imm,
   output logic [ADDR_LEN-1:0]   ex_pc,
   input  logic [DATA_LEN-1:0]   ex_result,
   input  logic [ADDR_LEN-1:0]   ex_target_pc,
   input  logic                  ex_jump_flag,
   output logic                  out_valid,
   output logic [ROB_ID_LEN-1:0] out_rob_id,
   output logic [DATA_LEN-1:0]   out_result,
   output logic [ADDR_LEN-1:0]   out_target_pc,
   output logic                  out_jump_flag
);

   localparam int IDX_W = $clog2(RS_SIZE);

   rs_op_t [RS_SIZE-1:0]                  op;
   logic   [RS_SIZE-1:0][ROB_ID_LEN-1:0]  q1, q2, rob;
   logic   [RS_SIZE-1:0]                  busy, q1_busy, q2_busy, ready, grant, ins_mask;
   logic   [IDX_W-1:0]                    sel_idx, ins_idx;
   logic                                  sel_any, do_ins;
   logic                                  new_q1b, new_q2b;
   logic   [DATA_LEN-1:0]                 new_v1, new_v2;

   rs_op_t                  iss_op;
   logic                    iss_valid;
   logic [ROB_ID_LEN-1:0]   iss_rob;

   // Own broadcast is checked first so it wins a tag collision with the CDB
   function automatic logic [DATA_LEN:0] wake(input logic qb,
                                              input logic [ROB_ID_LEN-1:0] q,
                                              input logic [DATA_LEN-1:0] v);
      if (qb && out_valid && out_rob_id == q) return {FALSE, out_result};
      if (qb && cdb_valid && cdb_rob_id == q) return {FALSE, cdb_value};
      return {qb, v};
   endfunction

   assign full     = &busy;
   assign ready    = busy & ~q1_busy & ~q2_busy;
   assign do_ins   = in_valid && !full;
   assign ins_mask = do_ins ? (RS_SIZE'(1) << ins_idx) : '0;

   always_comb begin
      ins_idx = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--)
         if (!busy[i]) ins_idx = IDX_W'(i);
   end

   always_comb begin
      {new_q1b, new_v1} = wake(in_Q1_busy, in_Q1, in_V1);
      {new_q2b, new_v2} = wake(in_Q2_busy, in_Q2, in_V2);
   end

`ifdef RS_OLDEST_FIRST_EN
   logic [RS_SIZE-1:0][RS_SIZE-1:0] older;

   // A new entry is younger than every surviving busy entry; its column is cleared
   always_ff @(posedge clk) begin
      if (rst) begin
         older <= '0;
      end else if (rdy && !rollback && do_ins) begin
         for (int r = 0; r < RS_SIZE; r++) older[r][ins_idx] <= FALSE;
         older[ins_idx] <= busy & ~grant;
      end
   end
`endif

   rs_select #(.N(RS_SIZE)) u_select (
      .ready (ready),
`ifdef RS_OLDEST_FIRST_EN
      .older (older),
`endif
      .grant (grant),
      .idx   (sel_idx),
      .any   (sel_any)
   );

   // Entry payload and tag state; validity is carried by busy, so no reset needed here
   always_ff @(posedge clk) begin
      if (!rst && rdy && !rollback) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            {q1_busy[i], op[i].v1} <= wake(q1_busy[i], q1[i], op[i].v1);
            {q2_busy[i], op[i].v2} <= wake(q2_busy[i], q2[i], op[i].v2);
         end
         if (do_ins) begin
            op[ins_idx]      <= rs_op_t'{in_openum, new_v1, new_v2, in_imm, in_pc};
            q1[ins_idx]      <= in_Q1;
            q2[ins_idx]      <= in_Q2;
            rob[ins_idx]     <= in_rob_id;
            q1_busy[ins_idx] <= new_q1b;
            q2_busy[ins_idx] <= new_q2b;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy          <= '0;
         iss_valid     <= FALSE;
         iss_op        <= NOP_OP;
         iss_rob       <= '0;
         out_valid     <= FALSE;
         out_rob_id    <= '0;
         out_result    <= ZERO_WORD;
         out_target_pc <= ZERO_ADDR;
         out_jump_flag <= FALSE;
      end else if (rdy) begin
         out_rob_id    <= iss_rob;
         out_result    <= ex_result;
         out_target_pc <= ex_target_pc;
         out_jump_flag <= ex_jump_flag;
         if (rollback) begin
            busy      <= '0;
            iss_valid <= FALSE;
            iss_op    <= NOP_OP;
            out_valid <= FALSE;
         end else begin
            busy      <= (busy & ~grant) | ins_mask;
            iss_valid <= sel_any;
            iss_op    <= sel_any ? op[sel_idx] : NOP_OP;
            iss_rob   <= sel_any ? rob[sel_idx] : '0;
            out_valid <= iss_valid;
         end
      end
   end

   assign ex_openum = iss_op.openum;
   assign ex_V1     = iss_op.v1;
   assign ex_V2     = iss_op.v2;
   assign ex_imm    = iss_op.imm;
   assign ex_pc     = iss_op.pc;

endmodule

// File: tb/tb_rs_scheduler.sv
// Directed bench for rs_scheduler: small external ALU model, scoreboard queue of expected broadcasts.
module tb_rs_scheduler;
   import rs_scheduler_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst, rdy, rollback, in_valid;
   logic [OPENUM_LEN-1:0] in_openum;
   logic [DATA_LEN-1:0]   in_V1, in_V2, in_imm;
   logic                  in_Q1_busy, in_Q2_busy;
   logic [3:0]            in_Q1, in_Q2, in_rob_id;
   logic [ADDR_LEN-1:0]   in_pc;
   logic                  full;
   logic                  cdb_valid;
   logic [3:0]            cdb_rob_id;
   logic [DATA_LEN-1:0]   cdb_value;
   logic [OPENUM_LEN-1:0] ex_openum;
   logic [DATA_LEN-1:0]   ex_V1, ex_V2, ex_imm, ex_result;
   logic [ADDR_LEN-1:0]   ex_pc, ex_target_pc;
   logic                  ex_jump_flag;
   logic                  out_valid;
   logic [3:0]            out_rob_id;
   logic [DATA_LEN-1:0]   out_result;
   logic [ADDR_LEN-1:0]   out_target_pc;
   logic                  out_jump_flag;

   typedef struct {
      logic [3:0]  rob;
      logic [31:0] res;
      logic [31:0] tpc;
      logic        jf;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   rs_scheduler dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .in_valid(in_valid), .in_openum(in_openum), .in_V1(in_V1), .in_V2(in_V2),
      .in_Q1_busy(in_Q1_busy), .in_Q2_busy(in_Q2_busy), .in_Q1(in_Q1), .in_Q2(in_Q2),
      .in_imm(in_imm), .in_pc(in_pc), .in_rob_id(in_rob_id), .full(full),
      .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
      .ex_openum(ex_openum), .ex_V1(ex_V1), .ex_V2(ex_V2), .ex_imm(ex_imm), .ex_pc(ex_pc),
      .ex_result(ex_result), .ex_target_pc(ex_target_pc), .ex_jump_flag(ex_jump_flag),
      .out_valid(out_valid), .out_rob_id(out_rob_id), .out_result(out_result),
      .out_target_pc(out_target_pc), .out_jump_flag(out_jump_flag)
   );

   // External ALU
   always_comb begin
      ex_result    = '0;
      ex_target_pc = '0;
      ex_jump_flag = 1'b0;
      case (ex_openum)
         OPENUM_ADD:  ex_result = ex_V1 + ex_V2;
         OPENUM_SUB:  ex_result = ex_V1 - ex_V2;
         OPENUM_ADDI: ex_result = ex_V1 + ex_imm;
         OPENUM_BEQ: begin
            ex_jump_flag = (ex_V1 == ex_V2);
            ex_target_pc = ex_pc + ex_imm;
         end
         default: ;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 0; in_openum = OPENUM_NOP; in_V1 = 0; in_V2 = 0; in_imm = 0; in_pc = 0;
      in_Q1_busy = 0; in_Q2_busy = 0; in_Q1 = 0; in_Q2 = 0; in_rob_id = 0;
      cdb_valid = 0; cdb_rob_id = 0; cdb_value = 0; rollback = 0;
   endtask

   task automatic ins(input logic [5:0] opc, input logic [31:0] v1, input logic [31:0] v2,
                      input logic q1b, input logic [3:0] q1, input logic q2b, input logic [3:0] q2,
                      input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
      in_valid = 1; in_openum = opc; in_V1 = v1; in_V2 = v2;
      in_Q1_busy = q1b; in_Q1 = q1; in_Q2_busy = q2b; in_Q2 = q2;
      in_imm = imm; in_pc = pc; in_rob_id = rob;
   endtask

   task automatic push(input logic [3:0] rob, input logic [31:0] res,
                       input logic [31:0] tpc, input logic jf);
      exp_t e;
      e.rob = rob; e.res = res; e.tpc = tpc; e.jf = jf;
      sb.push_back(e);
   endtask

   task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
      cdb_valid = 1; cdb_rob_id = tag; cdb_value = val;
   endtask

   initial begin
      rst = 1; rdy = 1; idle();

      fork
         forever begin
            @(negedge clk);
            if (!rst && rdy && out_valid) begin
               if (sb.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL unexpected_out: got rob %0d result 0x%0h, expected no broadcast",
                           out_rob_id, out_result);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("out_rob_id", 32'(out_rob_id), 32'(e.rob));
                  chk("out_result", out_result, e.res);
                  chk("out_target_pc", out_target_pc, e.tpc);
                  chk("out_jump_flag", 32'(out_jump_flag), 32'(e.jf));
               end
            end
         end
      join_none

      repeat (2) step();
      rst = 0;
      chk("rst_full", 32'(full), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_ex_openum", 32'(ex_openum), 32'(OPENUM_NOP));
      chk("rst_ex_V1", ex_V1, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_rob_id", 32'(out_rob_id), 0);

      // Single ADD: ex in cycle 2, out in cycle 3
      ins(OPENUM_ADD, 5, 7, 0, 0, 0, 0, 0, 0, 1);
      push(1, 12, 0, 0);
      step(); idle();
      chk("add_ex_c1_nop", 32'(ex_openum), 32'(OPENUM_NOP));
      step();
      chk("add_ex_c2_op", 32'(ex_openum), 32'(OPENUM_ADD));
      chk("add_ex_c2_v1", ex_V1, 5);
      chk("add_ex_c2_v2", ex_V2, 7);
      step();
      chk("add_out_c3_valid", 32'(out_valid), 1);
      step();
      chk("add_out_c4_pulse", 32'(out_valid), 0);

      // Branch: target and jump flag pass through
      ins(OPENUM_BEQ, 4, 4, 0, 0, 0, 0, 32'h20, 32'h100, 2);
      push(2, 0, 32'h120, 1);
      step(); idle();
      repeat (4) step();

      // Dependency via own broadcast
      ins(OPENUM_ADDI, 1, 0, 0, 0, 0, 0, 2, 0, 3);
      push(3, 3, 0, 0);
      step();
      ins(OPENUM_ADD, 0, 10, 1, 3, 0, 0, 0, 0, 4);
      push(4, 13, 0, 0);
      step(); idle();
      step();
      chk("dep_a_out_c3", 32'(out_valid), 1);
      chk("dep_a_rob_c3", 32'(out_rob_id), 3);
      step();
      chk("dep_gap_c4", 32'(out_valid), 0);
      step();
      chk("dep_gap_c5", 32'(out_valid), 0);
      step();
      chk("dep_b_out_c6", 32'(out_valid), 1);
      chk("dep_b_rob_c6", 32'(out_rob_id), 4);
      repeat (2) step();

      // Same-cycle CDB capture on insert
      cdb(5, 32'h40);
      ins(OPENUM_ADD, 0, 1, 1, 5, 0, 0, 0, 0, 6);
      push(6, 32'h41, 0, 0);
      step(); idle();
      step();
      chk("cap_ex_v1", ex_V1, 32'h40);
      repeat (3) step();

      // Own broadcast beats CDB on the same tag
      ins(OPENUM_ADDI, 32'h100, 0, 0, 0, 0, 0, 0, 0, 7);
      push(7, 32'h100, 0, 0);
      step();
      ins(OPENUM_ADD, 0, 1, 1, 7, 0, 0, 0, 0, 8);
      push(8, 32'h101, 0, 0);
      step(); idle();
      step();
      chk("prio_own_out", 32'(out_valid), 1);
      cdb(7, 32'hDEAD);
      step(); idle();
      repeat (5) step();

      // rdy low holds ex_* and blocks inserts
      ins(OPENUM_ADD, 2, 3, 0, 0, 0, 0, 0, 0, 9);
      push(9, 5, 0, 0);
      step(); idle();
      step();
      rdy = 0;
      ins(OPENUM_ADD, 1, 1, 0, 0, 0, 0, 0, 0, 10);
      chk("stall_ex_c2", 32'(ex_openum), 32'(OPENUM_ADD));
      step(); idle();
      chk("stall_ex_hold", 32'(ex_openum), 32'(OPENUM_ADD));
      chk("stall_out_low", 32'(out_valid), 0);
      step();
      rdy = 1;
      step();
      chk("stall_out_after", 32'(out_valid), 1);
      repeat (4) step();

      // Fill all 16 entries waiting on tag 9, alternating Q1/Q2
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0) ins(OPENUM_ADD, 0, 32'(i), 1, 9, 0, 0, 0, 0, 4'(i));
         else            ins(OPENUM_ADD, 32'(i), 0, 0, 0, 1, 9, 0, 0, 4'(i));
         push(4'(i), 32'h1000 + 32'(i), 0, 0);
         if (i == 15) chk("fill_not_full_c15", 32'(full), 0);
         step();
      end
      chk("fill_full", 32'(full), 1);
      ins(OPENUM_ADD, 32'h77, 0, 0, 0, 0, 0, 0, 0, 15);
      step(); idle();
      chk("fill_full_after_drop", 32'(full), 1);
      cdb(9, 32'h1000);
      step(); idle();
      chk("fill_full_wake", 32'(full), 1);
      step();
      chk("fill_full_drops", 32'(full), 0);
      step();
      for (int k = 0; k < 16; k++) begin
         chk("fill_burst_valid", 32'(out_valid), 1);
         step();
      end
      chk("fill_burst_end", 32'(out_valid), 0);
      repeat (2) step();

      // Rollback with 4 waiting entries and one issue in flight
      for (int i = 0; i < 4; i++) begin
         ins(OPENUM_ADD, 0, 1, 1, 2, 0, 0, 0, 0, 4'(10 + i));
         step();
      end
      ins(OPENUM_ADD, 1, 1, 0, 0, 0, 0, 0, 0, 14);
      step(); idle();
      step();
      chk("rb_ex_inflight", 32'(ex_openum), 32'(OPENUM_ADD));
      rollback = 1;
      ins(OPENUM_ADD, 3, 3, 0, 0, 0, 0, 0, 0, 15);
      step(); idle();
      chk("rb_full", 32'(full), 0);
      chk("rb_ex_nop", 32'(ex_openum), 32'(OPENUM_NOP));
      chk("rb_out_valid", 32'(out_valid), 0);
      step();
      chk("rb_no_stale", 32'(out_valid), 0);
      cdb(2, 5);
      step(); idle();
      for (int k = 0; k < 5; k++) begin
         chk("rb_flushed_quiet", 32'(out_valid), 0);
         step();
      end

      // Age order: slot 2 older than re-filled slot 0
      ins(OPENUM_ADD, 0, 0, 1, 3, 0, 0, 0, 0, 0);
      step();
      ins(OPENUM_ADD, 0, 1, 1, 1, 0, 0, 0, 0, 1);
      step();
      ins(OPENUM_ADD, 0, 2, 1, 2, 0, 0, 0, 0, 2);
      step(); idle();
      cdb(3, 32'h30);
      push(0, 32'h30, 0, 0);
      step(); idle();
      step();
      ins(OPENUM_ADD, 0, 3, 1, 2, 0, 0, 0, 0, 3);
      step(); idle();
      step();
      cdb(2, 32'h200);
`ifdef RS_OLDEST_FIRST_EN
      push(2, 32'h202, 0, 0);
      push(3, 32'h203, 0, 0);
`else
      push(3, 32'h203, 0, 0);
      push(2, 32'h202, 0, 0);
`endif
      step(); idle();
      repeat (5) step();
      cdb(1, 32'h100);
      push(1, 32'h101, 0, 0);
      step(); idle();

      for (int t = 0; t < 100 && sb.size() != 0; t++) step();
      repeat (3) step();
      chk("scoreboard_drained", 32'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
